// File: rtl/mips_arb_pkg.sv
// rtl/mips_arb_pkg.sv - shared types and constants for the data-memory arbiter
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/mips_arb_select.sv
// rtl/mips_arb_select.sv - winner selection: round-robin pointer or CPU priority with burst cap
module mips_arb_select
    import mips_arb_pkg::*;
#(
    parameter int ARB_MODE  = ARB_RR,
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant,
    output logic winner,
    output logic valid
);

    localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

    logic       ptr_q, ptr_d;
    logic [3:0] burst_q, burst_d;

    always_comb begin
        valid  = cpu_req | dma_req;
        winner = REQ_CPU;
        if (cpu_req && dma_req) begin
            if (ARB_MODE == ARB_FIXED) begin
                winner = (burst_q == BURST_CAP) ? REQ_DMA : REQ_CPU;
            end else begin
                winner = ptr_q;
            end
        end else if (dma_req) begin
            winner = REQ_DMA;
        end
    end

    // The burst counter only runs in fixed mode so it never wraps while unused.
    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if (grant && valid) begin
            ptr_d = ~winner;
            if (ARB_MODE == ARB_FIXED) begin
                if (winner == REQ_CPU && dma_req) begin
                    burst_d = burst_q + 4'd1;
                end else begin
                    burst_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= REQ_CPU;
            burst_q <= '0;
        end else if (clk_enable) begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// rtl/mips_data_mem_arbiter.sv - shares the data-memory port between the CPU and a DMA/debug loader
module mips_data_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ARB_MODE    = ARB_RR,
    parameter int MAX_BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_writedata,
    output logic [DATA_W-1:0] dma_readdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    arb_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] dma_rd_q, dma_rd_d;

    logic grant;
    logic sel_winner;
    logic sel_valid;

    mips_arb_select #(
        .ARB_MODE  (ARB_MODE),
        .MAX_BURST (MAX_BURST)
    ) u_select (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .grant      (grant),
        .winner     (sel_winner),
        .valid      (sel_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        cpu_rd_d = cpu_rd_q;
        dma_rd_d = dma_rd_q;
        grant    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant   = 1'b1;
                    owner_d = sel_winner;
                    if (sel_winner == REQ_DMA) begin
                        wr_d    = dma_write;
                        addr_d  = dma_address;
                        wdata_d = dma_writedata;
                    end else begin
                        wr_d    = cpu_write;
                        addr_d  = cpu_address;
                        wdata_d = cpu_writedata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Memory data is valid on the last wait cycle; only the owner's register moves.
                if (cnt_q == 3'd1) begin
                    if (owner_q == REQ_DMA) begin
                        dma_rd_d = mem_readdata;
                    end else begin
                        cpu_rd_d = mem_readdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= REQ_CPU;
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            cpu_rd_q <= cpu_rd_d;
            dma_rd_q <= dma_rd_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        mem_address   = addr_q;
        mem_writedata = wdata_q;
        mem_write     = (state_q == ACCESS) && wr_q;
        mem_read      = (state_q == ACCESS) && !wr_q;
        busy          = (state_q != IDLE);
        owner         = owner_q;
        cpu_ack       = (state_q == RESP) && (owner_q == REQ_CPU);
        dma_ack       = (state_q == RESP) && (owner_q == REQ_DMA);
        cpu_stall     = cpu_req && !cpu_ack;
        cpu_readdata  = cpu_rd_q;
        dma_readdata  = dma_rd_q;
    end

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// tb/tb_mips_data_mem_arbiter.sv - directed bench: dut0 latency 1 round-robin, dut1 latency 3 fixed priority
module tb_mips_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ce [2];
    logic        cpu_req [2], cpu_write [2], dma_req [2], dma_write [2];
    logic [31:0] cpu_address [2], cpu_writedata [2], dma_address [2], dma_writedata [2];
    logic [31:0] cpu_readdata [2], dma_readdata [2], mem_address [2], mem_writedata [2], mem_readdata [2];
    logic        cpu_ack [2], cpu_stall [2], dma_ack [2], mem_write [2], mem_read [2], owner [2], busy [2];

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    always @(posedge clk) begin
        if (mem_write[0]) mem0[mem_address[0][7:2]] <= mem_writedata[0];
        if (mem_write[1]) mem1[mem_address[1][7:2]] <= mem_writedata[1];
    end
    assign mem_readdata[0] = mem0[mem_address[0][7:2]];
    assign mem_readdata[1] = mem1[mem_address[1][7:2]];

    mips_data_mem_arbiter #(.MEM_LATENCY(1), .ARB_MODE(0), .MAX_BURST(4)) dut0 (
        .clk(clk), .reset(reset), .clk_enable(ce[0]),
        .cpu_req(cpu_req[0]), .cpu_write(cpu_write[0]), .cpu_address(cpu_address[0]),
        .cpu_writedata(cpu_writedata[0]), .cpu_readdata(cpu_readdata[0]), .cpu_ack(cpu_ack[0]),
        .cpu_stall(cpu_stall[0]),
        .dma_req(dma_req[0]), .dma_write(dma_write[0]), .dma_address(dma_address[0]),
        .dma_writedata(dma_writedata[0]), .dma_readdata(dma_readdata[0]), .dma_ack(dma_ack[0]),
        .mem_address(mem_address[0]), .mem_write(mem_write[0]), .mem_read(mem_read[0]),
        .mem_writedata(mem_writedata[0]), .mem_readdata(mem_readdata[0]),
        .owner(owner[0]), .busy(busy[0])
    );

    mips_data_mem_arbiter #(.MEM_LATENCY(3), .ARB_MODE(1), .MAX_BURST(4)) dut1 (
        .clk(clk), .reset(reset), .clk_enable(ce[1]),
        .cpu_req(cpu_req[1]), .cpu_write(cpu_write[1]), .cpu_address(cpu_address[1]),
        .cpu_writedata(cpu_writedata[1]), .cpu_readdata(cpu_readdata[1]), .cpu_ack(cpu_ack[1]),
        .cpu_stall(cpu_stall[1]),
        .dma_req(dma_req[1]), .dma_write(dma_write[1]), .dma_address(dma_address[1]),
        .dma_writedata(dma_writedata[1]), .dma_readdata(dma_readdata[1]), .dma_ack(dma_ack[1]),
        .mem_address(mem_address[1]), .mem_write(mem_write[1]), .mem_read(mem_read[1]),
        .mem_writedata(mem_writedata[1]), .mem_readdata(mem_readdata[1]),
        .owner(owner[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ack_at counts falling edges after the req-sampling edge; -1 means the bound expired.
    task automatic do_xfer(input int d, input bit p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int freeze_at,
                           output int ack_at, output int wr_cyc, output int rd_cyc,
                           output logic [31:0] wr_addr, output logic [31:0] rdata);
        ack_at  = -1;
        wr_cyc  = 0;
        rd_cyc  = 0;
        wr_addr = '0;
        if (!p) begin
            cpu_req[d] = 1'b1; cpu_write[d] = wr; cpu_address[d] = addr; cpu_writedata[d] = wdata;
        end else begin
            dma_req[d] = 1'b1; dma_write[d] = wr; dma_address[d] = addr; dma_writedata[d] = wdata;
        end
        for (int n = 1; n <= 60 && ack_at < 0; n++) begin
            @(negedge clk);
            if (mem_write[d]) begin
                wr_cyc++;
                wr_addr = mem_address[d];
            end
            if (mem_read[d]) rd_cyc++;
            if (!p && n == 1) check_eq("cpu_stall_busy", 64'(cpu_stall[d]), 64'd1);
            if (freeze_at > 0 && n == freeze_at) ce[d] = 1'b0;
            if (freeze_at > 0 && n == freeze_at + 5) ce[d] = 1'b1;
            if ((!p && cpu_ack[d]) || (p && dma_ack[d])) begin
                ack_at = n;
                cpu_req[d] = 1'b0;
                dma_req[d] = 1'b0;
            end
        end
        ce[d] = 1'b1;
        rdata = p ? dma_readdata[d] : cpu_readdata[d];
        cpu_req[d] = 1'b0;
        dma_req[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_contest(input int d, input int n_tx, output logic [15:0] seq);
        int got;
        got = 0;
        seq = '0;
        cpu_req[d] = 1'b1; cpu_write[d] = 1'b1; cpu_address[d] = 32'h20; cpu_writedata[d] = 32'hC0;
        dma_req[d] = 1'b1; dma_write[d] = 1'b1; dma_address[d] = 32'h24; dma_writedata[d] = 32'hD0;
        for (int n = 0; n < 200 && got < n_tx; n++) begin
            @(negedge clk);
            if (cpu_ack[d]) begin seq = {seq[14:0], 1'b0}; got++; end
            if (dma_ack[d]) begin seq = {seq[14:0], 1'b1}; got++; end
        end
        check_eq("contest_count", 64'(got), 64'(n_tx));
        cpu_req[d] = 1'b0;
        dma_req[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int          ack_at, wr_cyc, rd_cyc, stray;
    logic [31:0] wr_addr, rdata;
    logic [15:0] seq;

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b1;
            cpu_req[d] = 1'b0; cpu_write[d] = 1'b0; cpu_address[d] = '0; cpu_writedata[d] = '0;
            dma_req[d] = 1'b0; dma_write[d] = 1'b0; dma_address[d] = '0; dma_writedata[d] = '0;
        end
        repeat (3) @(negedge clk);

        check_eq("rst_busy", 64'(busy[0]), 64'd0);
        check_eq("rst_mem_write", 64'(mem_write[0]), 64'd0);
        check_eq("rst_mem_read", 64'(mem_read[1]), 64'd0);
        check_eq("rst_cpu_ack", 64'(cpu_ack[0]), 64'd0);
        check_eq("rst_dma_ack", 64'(dma_ack[1]), 64'd0);
        check_eq("rst_owner", 64'(owner[1]), 64'd0);
        check_eq("rst_cpu_readdata", 64'(cpu_readdata[0]), 64'd0);
        check_eq("rst_mem_address", 64'(mem_address[0]), 64'd0);
        reset = 1'b1;

        do_xfer(0, 1'b0, 1'b1, 32'h10, 32'h0000_1234, 0, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("wr_ack_latency", 64'(ack_at), 64'd2);
        check_eq("wr_mem_write_cycles", 64'(wr_cyc), 64'd1);
        check_eq("wr_mem_address", 64'(wr_addr), 64'h10);

        do_xfer(1, 1'b0, 1'b1, 32'h10, 32'h0000_1234, 0, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("wr1_ack_latency", 64'(ack_at), 64'd2);

        do_xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, 0, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("rd_lat1_ack", 64'(ack_at), 64'd3);
        check_eq("rd_lat1_data", 64'(rdata), 64'h1234);
        check_eq("rd_lat1_read_cycles", 64'(rd_cyc), 64'd1);
        check_eq("rd_lat1_dma_untouched", 64'(dma_readdata[0]), 64'd0);

        do_xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 0, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("rd_lat3_ack", 64'(ack_at), 64'd5);
        check_eq("rd_lat3_data", 64'(rdata), 64'h1234);
        check_eq("rd_lat3_dma_untouched", 64'(dma_readdata[1]), 64'd0);

        do_xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 2, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("freeze_ack", 64'(ack_at), 64'd10);
        check_eq("freeze_data", 64'(rdata), 64'h1234);

        dma_req[1] = 1'b1; dma_write[1] = 1'b0; dma_address[1] = 32'h10; dma_writedata[1] = '0;
        repeat (2) @(negedge clk);
        check_eq("dma_in_wait_busy", 64'(busy[1]), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_mem_read", 64'(mem_read[1]), 64'd0);
        check_eq("async_rst_busy", 64'(busy[1]), 64'd0);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (dma_ack[1]) stray++;
        end
        check_eq("rst_no_dma_ack", 64'(stray), 64'd0);
        reset = 1'b1;
        do_xfer(1, 1'b1, 1'b0, 32'h10, 32'h0, 0, ack_at, wr_cyc, rd_cyc, wr_addr, rdata);
        check_eq("post_rst_dma_ack", 64'(ack_at), 64'd5);
        check_eq("post_rst_dma_read_cycles", 64'(rd_cyc), 64'd1);
        check_eq("post_rst_dma_data", 64'(rdata), 64'h1234);

        pulse_reset();
        run_contest(0, 6, seq);
        check_eq("rr_owner_seq", 64'(seq), 64'h0015);

        pulse_reset();
        run_contest(1, 10, seq);
        check_eq("fixed_owner_seq", 64'(seq), 64'h0021);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_data_mem_arbiter.md
Name: mips_data_mem_arbiter

Overview:
Shares the single data-memory port (mips_cpu_data_memory) between two requesters: port 0 is the mips_cpu_harvard data interface and port 1 is a DMA/debug loader that preloads or inspects data memory. Each access is a one-transaction-at-a-time req/ack handshake, and the arbiter drives the memory's data_address, data_write, data_read and data_writedata. The block sits between the CPU, the loader and data memory, and produces the CPU stall condition.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LATENCY, 1, cycles from the read-issue cycle until mem_readdata is valid; legal range is 1..7.
ARB_MODE, 0, selects arbitration: 0 = round-robin, 1 = fixed CPU priority with a burst cap.
MAX_BURST, 4, number of consecutive CPU grants allowed while the DMA waits (used only when ARB_MODE = 1); legal range is 1..15.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  asynchronous, active-low reset.
clk_enable  in  1  when low, the FSM, counters and registers hold.
cpu_req  in  1  CPU access request.
cpu_write  in  1  1 = write, 0 = read.
cpu_address  in  ADDR_W  byte address.
cpu_writedata  in  DATA_W  write data.
cpu_readdata  out  DATA_W  registered read data.
cpu_ack  out  1  one-cycle completion pulse.
cpu_stall  out  1  equals cpu_req & ~cpu_ack.
dma_req, dma_write, dma_address, dma_writedata  in  same widths and meaning as the CPU inputs.
dma_readdata  out  DATA_W.
dma_ack  out  1.
mem_address  out  ADDR_W  to data memory.
mem_write  out  1.
mem_read  out  1.
mem_writedata  out  DATA_W.
mem_readdata  in  DATA_W.
owner  out  1  requester of the current transaction (0 = CPU, 1 = DMA); valid while busy.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset value of all outputs is 0. The FSM resets to IDLE, the round-robin pointer to CPU, and the burst counter to 0.
- Reset asserted mid-transaction abandons the transaction. mem_write and mem_read drop asynchronously, no ack is issued, and requesters must re-issue.
- Handshake rules:
  - A requester holds req high with stable write/address/writedata until it sees ack.
  - Ack is high for exactly one cycle.
  - Req still high in the cycle after ack is a new transaction.
- FSM states are IDLE, ACCESS, WAIT and RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner, latch its write/address/writedata and owner, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_writedata come from the latched values.
  - mem_write = latched write; mem_read = ~latched write.
  - A write goes to RESP. A read loads the latency counter with MEM_LATENCY and goes to WAIT.
- WAIT:
  - The counter decrements each cycle, with mem_read and mem_write both low.
  - On the cycle the counter reaches 1, capture mem_readdata into the owner's readdata register and go to RESP.
- RESP (1 cycle): the owner's ack is high, then the FSM returns to IDLE. The non-owner's readdata is unchanged.
- Latency from the req-sampling edge to the ack cycle:
  - Write: 2 cycles.
  - Read: 2 + MEM_LATENCY cycles.
  - Throughput is one transaction per 3 cycles (writes) or 3 + MEM_LATENCY cycles (reads).
- Round-robin (ARB_MODE = 0):
  - When both requesters are high, the pointer holder wins.
  - After every grant the pointer moves to the non-winner.
  - A single requester always wins, and the pointer still updates.
- Fixed priority (ARB_MODE = 1):
  - The CPU wins ties.
  - The burst counter increments on each CPU grant made while dma_req is high; it clears on a DMA grant and on a CPU grant made while dma_req is low.
  - When the counter equals MAX_BURST and both requesters are high, the DMA wins.
- Requests arriving during ACCESS, WAIT or RESP wait for IDLE; there is no preemption.
- Reads and writes to the same address by different owners are serialised in grant order; there is no forwarding.
- clk_enable low freezes all state; mem_write and mem_read keep their current values.

Decomposition:
- Package mips_arb_pkg holds:
  - The arb_state_t enum (IDLE, ACCESS, WAIT, RESP).
  - The ARB_RR and ARB_FIXED constants.
  - The REQ_CPU = 0 and REQ_DMA = 1 ids.
- Sub-module mips_arb_select holds the winner logic: the round-robin pointer and the burst counter. Its inputs are the two reqs and a grant strobe; its outputs are the winner id and a valid flag.

Test Plan:
- Reset low, then CPU writes 0x0000_1234 to 0x10 -> mem_write high for exactly 1 cycle with mem_address = 0x10; cpu_ack fires 2 cycles after the req is sampled.
- CPU reads 0x10 with MEM_LATENCY = 1 and then 3 -> cpu_readdata = 0x0000_1234 and cpu_ack at +3 and +5 cycles respectively; dma_readdata stays 0.
- ARB_MODE = 0, both requesters continuously requesting writes for 6 transactions -> owner sequence is 0,1,0,1,0,1.
- ARB_MODE = 1, MAX_BURST = 4, both continuously requesting -> owner sequence is 0,0,0,0,1,0,0,0,0,1.
- Reset asserted during WAIT of a DMA read -> mem_read is 0 immediately and no dma_ack occurs; after release with dma_req still high -> a fresh ACCESS begins and completes normally.
- clk_enable low for 5 cycles during WAIT -> the state and counter hold, and ack is delayed by exactly 5 cycles.
